blink_decoder: RTL and testbench
================================

Name: blink_decoder

Overview:
- Receives the LED blink code driven by the pin-scan blink generator and recovers the column and row numbers it encodes.
- The code is made of three parts:
  - preamble: a burst of 1-cycle toggles;
  - column count: N pulses, each 8 cycles high in a 16-cycle slot, then a dark pause;
  - row count: M pulses in the same form, then a long dark tail.
- The block sits on a second board, or on a loop-back pin, fed from the probed pin. It emits one `col`/`row` pair per decoded frame for the host or UART logger.

Parameters:
- COUNT_W, 4, width of the `col_out`/`row_out` counters; max decodable value is 2^COUNT_W-1.
- SHORT_MAX, 2, max high length (cycles) of a preamble toggle pulse.
- PRE_MIN, 8, consecutive short pulses required to declare preamble.
- PULSE_MIN, 6, min high length of a data pulse.
- PULSE_MAX, 10, max high length of a data pulse.
- GAP_SEP, 20, low run (cycles) separating the column group from the row group.
- END_GAP, 96, low run ending the row group; must exceed 8+16*pauze.
- LEN_W, 8, width of the run-length counters (saturating).

Ports:
- clk  in  1  system clock, same domain as the generator.
- reset  in  1  synchronous, active-high.
- probe  in  1  asynchronous blink input.
- col_out  out  COUNT_W  last decoded column.
- row_out  out  COUNT_W  last decoded row.
- valid  out  1  one-cycle pulse when `col_out`/`row_out` update.
- err  out  1  one-cycle pulse on a malformed frame.
- locked  out  1  high while state != HUNT.

Behaviour:
- Reset: sync flops, run counters, `short_cnt`, `col_cnt`, `row_cnt`, `col_out`, `row_out`, `valid`, `err` all 0; state HUNT.
  - Reset mid-frame aborts the frame silently, with no `err`.
- Synchronisation:
  - `probe` passes through a 2-FF synchroniser to give `s`; `s_d` is `s` delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- Run-length counters:
  - While s=1: `high_len` <= sat(`high_len`+1), `low_len` <= 0.
  - While s=0: `low_len` <= sat(`low_len`+1).
  - On a fall cycle, `high_len` is evaluated, then cleared.
- Pulse classes, evaluated on fall:
  - short: 1..SHORT_MAX;
  - data: PULSE_MIN..PULSE_MAX;
  - otherwise bad.
- Gap events fire once per low run:
  - gapS when s=0 and `low_len` == GAP_SEP-1;
  - gapE when s=0 and `low_len` == END_GAP-1;
  - gapH when s=0 and `low_len` == SHORT_MAX.
- FSM states and transitions:
  - HUNT:
    - short fall: `short_cnt`++;
    - data or bad fall: `short_cnt`=0;
    - gapH: `short_cnt`=0;
    - `short_cnt` reaching PRE_MIN: go to PRE, `short_cnt`=0.
  - PRE:
    - short fall: stay;
    - data fall: `col_cnt`=1, go to COL;
    - bad fall or gapS: `err`, go to HUNT.
  - COL:
    - data fall: `col_cnt`++; if `col_cnt` is already 2^COUNT_W-1, `err` and go to HUNT (overflow);
    - short or bad fall: `err`, go to HUNT;
    - gapS: `row_cnt`=0, go to ROW.
  - ROW:
    - data fall: `row_cnt`++ (same overflow rule);
    - short or bad fall: `err`, go to HUNT;
    - rise after gapS with `row_cnt`>=1 (a third group): `err`, go to HUNT;
    - gapE with `row_cnt`>=1: `col_out`<=`col_cnt`, `row_out`<=`row_cnt`, `valid`=1 for one cycle, go to HUNT;
    - gapE with `row_cnt`==0: `err`, go to HUNT.
- Simultaneous events: a fall and a gap event cannot coincide, since gap events need s=0 with `low_len`>=1.
  - PRE_MIN reached and `err` in the same cycle is impossible.
- Column or row value 0 is not encodable; it surfaces as `err`.
- `col_out`/`row_out` hold their value until the next `valid` and are unaffected by `err`.
- Latency: `valid` asserts END_GAP+2 cycles after the last row pulse's falling edge on `probe`.
- After `valid`, the next frame's preamble re-locks from HUNT.
  - With the generator's 2048-cycle frame, every frame decodes.

Test Plan:
- Generator model, preamble=1, col=7, pauze=3, row=5 -> `valid` once per 2048-cycle frame; `col_out`=7, `row_out`=5; `valid` END_GAP+2 cycles after the probe falls at cycle 272; `err` never.
- col=1, pauze=1, row=1 -> `col_out`=1, `row_out`=1; `locked` high from preamble lock to `valid`.
- `reset` asserted for 3 cycles during the 4th column pulse -> no `valid`, no `err` for that frame; next frame gives 7/5.
- Inject a 12-cycle high pulse in place of the 3rd column pulse -> `err` pulse, state HUNT, `col_out`/`row_out` unchanged; next clean frame gives 7/5.
- Injected 15 column and 15 row pulses -> 15/15.
  - 16 column pulses -> `err` on the 16th fall, no `valid`.
- 5 isolated short pulses then 200 low cycles -> `locked`=0 throughout, no `valid`, no `err`.

Source files
------------

// File: rtl/blink_decoder.sv
// blink_decoder: recovers the column and row numbers carried by the pin-scan
// blink code on `probe`.
//
// A frame is a preamble burst of 1-cycle toggles, a group of ~8-cycle column
// pulses, a dark pause, a group of row pulses and a long dark tail. The input
// is synchronised, measured as high/low run lengths, classified into
// short/data/bad pulses and gap events, and walked through a small FSM.
//
// Output handshake: `valid` is a single-cycle strobe with no back-pressure.
// `col_out`/`row_out` change only in the cycle `valid` is high and then hold
// until the next `valid`. `err` is a single-cycle strobe marking a malformed
// frame and never disturbs `col_out`/`row_out`. `locked` is the FSM-state
// view: high whenever the decoder is inside a frame (state != HUNT).

module blink_decoder #(
    parameter int COUNT_W   = 4,
    parameter int SHORT_MAX = 2,
    parameter int PRE_MIN   = 8,
    parameter int PULSE_MIN = 6,
    parameter int PULSE_MAX = 10,
    parameter int GAP_SEP   = 20,
    parameter int END_GAP   = 96,
    parameter int LEN_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               probe,
    output logic [COUNT_W-1:0] col_out,
    output logic [COUNT_W-1:0] row_out,
    output logic               valid,
    output logic               err,
    output logic               locked
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        HUNT = 2'd0,   // searching for a preamble
        PRE  = 2'd1,   // preamble seen, waiting for the first column pulse
        COL  = 2'd2,   // counting column pulses
        ROW  = 2'd3    // counting row pulses
    } state_t;

    localparam int SHORT_W = $clog2(PRE_MIN + 1);

    localparam logic [LEN_W-1:0]   LEN_ZERO    = '0;
    localparam logic [LEN_W-1:0]   LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_SAT     = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0]   SHORT_MAX_L = LEN_W'(SHORT_MAX);
    localparam logic [LEN_W-1:0]   PULSE_MIN_L = LEN_W'(PULSE_MIN);
    localparam logic [LEN_W-1:0]   PULSE_MAX_L = LEN_W'(PULSE_MAX);
    localparam logic [LEN_W-1:0]   GAP_SEP_L   = LEN_W'(GAP_SEP - 1);
    localparam logic [LEN_W-1:0]   GAP_END_L   = LEN_W'(END_GAP - 1);

    localparam logic [COUNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = {COUNT_W{1'b1}};

    localparam logic [SHORT_W-1:0] SHORT_ZERO  = '0;
    localparam logic [SHORT_W-1:0] SHORT_ONE   = SHORT_W'(1);
    localparam logic [SHORT_W-1:0] PRE_LAST    = SHORT_W'(PRE_MIN - 1);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    // Synchroniser and edge detection.
    logic               sync1_q;
    logic               s_q;
    logic               s_dly_q;
    logic               rise;
    logic               fall;

    // Run-length counters.
    logic [LEN_W-1:0]   high_len_q;
    logic [LEN_W-1:0]   high_len_d;
    logic [LEN_W-1:0]   low_len_q;
    logic [LEN_W-1:0]   low_len_d;

    // Pulse classes (valid only on a fall cycle) and gap events.
    logic               pulse_short;
    logic               pulse_data;
    logic               pulse_bad;
    logic               gap_h;
    logic               gap_s;
    logic               gap_e;

    // Frame FSM and its counters.
    state_t             state_q;
    state_t             state_d;
    logic [SHORT_W-1:0] short_cnt_q;
    logic [SHORT_W-1:0] short_cnt_d;
    logic [COUNT_W-1:0] col_cnt_q;
    logic [COUNT_W-1:0] col_cnt_d;
    logic [COUNT_W-1:0] row_cnt_q;
    logic [COUNT_W-1:0] row_cnt_d;
    logic               row_gap_q;   // row group closed by a separator gap
    logic               row_gap_d;

    // Registered outputs.
    logic [COUNT_W-1:0] col_out_q;
    logic [COUNT_W-1:0] col_out_d;
    logic [COUNT_W-1:0] row_out_q;
    logic [COUNT_W-1:0] row_out_d;
    logic               valid_q;
    logic               valid_d;
    logic               err_q;
    logic               err_d;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous probe plus a one-cycle delay for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            sync1_q <= probe;
            s_q     <= sync1_q;
            s_dly_q <= s_q;
        end
    end

    assign rise = s_q & ~s_dly_q;
    assign fall = ~s_q & s_dly_q;

    // ------------------------------------------------------------------
    // Run-length counters
    // ------------------------------------------------------------------
    // Next-state of the saturating high/low run counters; high run is cleared after a fall.
    always_comb begin
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        if (s_q) begin
            high_len_d = (high_len_q == LEN_SAT) ? LEN_SAT : high_len_q + LEN_ONE;
            low_len_d  = LEN_ZERO;
        end else begin
            low_len_d = (low_len_q == LEN_SAT) ? LEN_SAT : low_len_q + LEN_ONE;
            if (fall) begin
                high_len_d = LEN_ZERO;
            end
        end
    end

    // Run-length counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_len_q <= LEN_ZERO;
            low_len_q  <= LEN_ZERO;
        end else begin
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse classification and gap events
    // ------------------------------------------------------------------
    // On a fall cycle high_len_q still holds the length of the pulse that just ended.
    // Each gap compare hits one low_len value, so each event fires once per low run
    // (saturation parks the counter far above every threshold).
    always_comb begin
        pulse_short = 1'b0;
        pulse_data  = 1'b0;
        pulse_bad   = 1'b0;
        if (fall) begin
            if ((high_len_q != LEN_ZERO) && (high_len_q <= SHORT_MAX_L)) begin
                pulse_short = 1'b1;
            end else if ((high_len_q >= PULSE_MIN_L) && (high_len_q <= PULSE_MAX_L)) begin
                pulse_data = 1'b1;
            end else begin
                pulse_bad = 1'b1;
            end
        end
        gap_h = ~s_q && (low_len_q == SHORT_MAX_L);
        gap_s = ~s_q && (low_len_q == GAP_SEP_L);
        gap_e = ~s_q && (low_len_q == GAP_END_L);
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // Next-state, counter and output logic of the frame decoder.
    always_comb begin
        state_d     = state_q;
        short_cnt_d = short_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        row_gap_d   = row_gap_q;
        col_out_d   = col_out_q;
        row_out_d   = row_out_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            HUNT: begin
                row_gap_d = 1'b0;
                if (pulse_short) begin
                    if (short_cnt_q == PRE_LAST) begin
                        short_cnt_d = SHORT_ZERO;
                        state_d     = PRE;
                    end else begin
                        short_cnt_d = short_cnt_q + SHORT_ONE;
                    end
                end else if (pulse_data || pulse_bad || gap_h) begin
                    // Any non-toggle pulse or a low run longer than a toggle breaks the burst.
                    short_cnt_d = SHORT_ZERO;
                end
            end

            PRE: begin
                if (pulse_data) begin
                    col_cnt_d = CNT_ONE;
                    state_d   = COL;
                end else if (pulse_bad || gap_s) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end
            end

            COL: begin
                if (pulse_data) begin
                    if (col_cnt_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_ONE;
                    end
                end else if (pulse_short || pulse_bad) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else if (gap_s) begin
                    row_cnt_d = CNT_ZERO;
                    row_gap_d = 1'b0;
                    state_d   = ROW;
                end
            end

            ROW: begin
                if (pulse_data) begin
                    if (row_cnt_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        row_cnt_d = row_cnt_q + CNT_ONE;
                    end
                end else if (pulse_short || pulse_bad) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else if (rise && row_gap_q) begin
                    // Light after the row group has been closed: a third group.
                    err_d   = 1'b1;
                    state_d = HUNT;
                end else if (gap_s && (row_cnt_q != CNT_ZERO)) begin
                    row_gap_d = 1'b1;
                end else if (gap_e) begin
                    if (row_cnt_q != CNT_ZERO) begin
                        col_out_d = col_cnt_q;
                        row_out_d = row_cnt_q;
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = HUNT;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // FSM state, frame counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            short_cnt_q <= SHORT_ZERO;
            col_cnt_q   <= CNT_ZERO;
            row_cnt_q   <= CNT_ZERO;
            row_gap_q   <= 1'b0;
            col_out_q   <= CNT_ZERO;
            row_out_q   <= CNT_ZERO;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            short_cnt_q <= short_cnt_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            row_gap_q   <= row_gap_d;
            col_out_q   <= col_out_d;
            row_out_q   <= row_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign col_out = col_out_q;
    assign row_out = row_out_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign locked  = (state_q != HUNT);

endmodule

// File: tb/tb_blink_decoder.sv
// Bench for blink_decoder: builds probe waveforms from frame descriptions
// (preamble, column count, pause, row count), plays them cycle by cycle and
// compares the decoded frames against what each description should yield.

module tb_blink_decoder;

    localparam int COUNT_W = 4;
    localparam int END_GAP = 96;
    localparam int LAT     = END_GAP + 2;  // probe fall -> valid, in cycles
    localparam int ERR_LAT = 3;            // probe fall -> err, in cycles
    localparam int FRAME   = 2048;
    localparam int PRE_LEN = 32;           // 16 one-cycle toggles
    localparam int LOCK_AT = 18;           // 8th toggle falls at index 15, plus 3

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               reset;
    logic               probe;
    logic [COUNT_W-1:0] col_out;
    logic [COUNT_W-1:0] row_out;
    logic               valid;
    logic               err;
    logic               locked;

    always #5 clk = ~clk;

    blink_decoder dut (
        .clk     (clk),
        .reset   (reset),
        .probe   (probe),
        .col_out (col_out),
        .row_out (row_out),
        .valid   (valid),
        .err     (err),
        .locked  (locked)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- stimulus storage ----------------
    bit wave_q[$];
    bit rst_q[$];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];       // {col,row} expected per valid
    int         exp_idx_q[$];   // cycle index expected per valid
    logic [7:0] obs_q[$];
    int         obs_vidx[$];
    int         obs_eidx[$];
    int         lock_first;
    int         lock_cnt;

    // ---------------- driver tasks ----------------
    task automatic add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            wave_q.push_back(v);
            rst_q.push_back(1'b0);
        end
    endtask

    task automatic add_pulse(input int len);
        add_level(1'b0, 16 - len);
        add_level(1'b1, len);
    endtask

    // One generator frame built from explicit pulse lengths; padded to FRAME cycles.
    task automatic add_frame_q(input int cl[$], input int pauze, input int rl[$],
                               input int third_gap, output int last_fall);
        int start;
        start = wave_q.size();
        for (int i = 0; i < PRE_LEN / 2; i++) begin
            add_level(1'b1, 1);
            add_level(1'b0, 1);
        end
        foreach (cl[i]) add_pulse(cl[i]);
        add_level(1'b0, 16 * pauze);
        foreach (rl[i]) add_pulse(rl[i]);
        last_fall = wave_q.size();
        if (third_gap > 0) begin
            add_level(1'b0, third_gap);
            add_level(1'b1, 8);
        end
        add_level(1'b0, start + FRAME - wave_q.size());
    endtask

    task automatic add_frame(input int col, input int pauze, input int row,
                             input bit rnd, output int last_fall);
        int cl[$];
        int rl[$];
        for (int i = 0; i < col; i++) cl.push_back(rnd ? int'($urandom_range(6, 10)) : 8);
        for (int i = 0; i < row; i++) rl.push_back(rnd ? int'($urandom_range(6, 10)) : 8);
        add_frame_q(cl, pauze, rl, 0, last_fall);
    endtask

    // Drive the built waveform; outputs are sampled on the falling edge.
    task automatic play();
        obs_q.delete();
        obs_vidx.delete();
        obs_eidx.delete();
        lock_first = -1;
        lock_cnt   = 0;
        for (int k = 0; k < wave_q.size(); k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                obs_q.push_back({col_out, row_out});
                obs_vidx.push_back(k);
            end
            if (err === 1'b1) obs_eidx.push_back(k);
            if (locked === 1'b1) begin
                lock_cnt++;
                if (lock_first < 0) lock_first = k;
            end
            probe = wave_q[k];
            reset = rst_q[k];
        end
        probe = 1'b0;
        reset = 1'b0;
        wave_q.delete();
        rst_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        probe = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (col_out !== 4'd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", col_out); end
        n_checks++;
        if (row_out !== 4'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", row_out); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nominal();
        int lf;
        for (int f = 0; f < 2; f++) begin
            add_frame(7, 3, 5, 1'b0, lf);
            exp_q.push_back({4'd7, 4'd5});
            exp_idx_q.push_back(lf + LAT);
        end
        play();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL nominal_count: got %0d valids want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL nominal_value[%0d]: got col=%0d row=%0d want col=%0d row=%0d",
                                   i, obs_q[i][7:4], obs_q[i][3:0], exp_q[i][7:4], exp_q[i][3:0]);
            end
            n_checks++;
            if (obs_vidx[i] != exp_idx_q[i]) begin
                n_fail++; $display("FAIL nominal_latency[%0d]: got cycle %0d want %0d", i, obs_vidx[i], exp_idx_q[i]);
            end
        end
        n_checks++;
        if (obs_eidx.size() != 0) begin n_fail++; $display("FAIL nominal_err: got %0d errs want 0", obs_eidx.size()); end
        exp_q.delete();
        exp_idx_q.delete();
    endtask

    task automatic test_min_frame();
        int lf;
        add_frame(1, 1, 1, 1'b0, lf);
        play();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL min_count: got %0d valids want 1", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {4'd1, 4'd1}) begin
                n_fail++; $display("FAIL min_value: got col=%0d row=%0d want col=1 row=1", obs_q[0][7:4], obs_q[0][3:0]);
            end
            n_checks++;
            if (obs_vidx[0] != lf + LAT) begin
                n_fail++; $display("FAIL min_latency: got cycle %0d want %0d", obs_vidx[0], lf + LAT);
            end
        end
        n_checks++;
        if (lock_first != LOCK_AT) begin n_fail++; $display("FAIL min_lock_start: got %0d want %0d", lock_first, LOCK_AT); end
        n_checks++;
        if (lock_cnt != lf + LAT - LOCK_AT) begin
            n_fail++; $display("FAIL min_lock_len: got %0d want %0d", lock_cnt, lf + LAT - LOCK_AT);
        end
        n_checks++;
        if (obs_eidx.size() != 0) begin n_fail++; $display("FAIL min_err: got %0d errs want 0", obs_eidx.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int lf0;
        int lf1;
        add_frame(7, 3, 5, 1'b0, lf0);
        // 4th column pulse is high over indices 88..95
        for (int i = 90; i < 93; i++) rst_q[i] = 1'b1;
        add_frame(7, 3, 5, 1'b0, lf1);
        play();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL rstmid_count: got %0d valids want 1", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {4'd7, 4'd5}) begin
                n_fail++; $display("FAIL rstmid_value: got col=%0d row=%0d want col=7 row=5", obs_q[0][7:4], obs_q[0][3:0]);
            end
            n_checks++;
            if (obs_vidx[0] != lf1 + LAT) begin
                n_fail++; $display("FAIL rstmid_latency: got cycle %0d want %0d", obs_vidx[0], lf1 + LAT);
            end
        end
        n_checks++;
        if (obs_eidx.size() != 0) begin n_fail++; $display("FAIL rstmid_err: got %0d errs want 0", obs_eidx.size()); end
    endtask

    task automatic test_bad_pulse();
        int cl[$];
        int rl[$];
        int lf;
        cl = '{8, 8, 12, 8, 8, 8, 8};
        rl = '{8, 8, 8, 8, 8};
        add_frame_q(cl, 3, rl, 0, lf);
        play();
        n_checks++;
        if (obs_eidx.size() != 1) begin
            n_fail++; $display("FAIL bad_err_count: got %0d want 1", obs_eidx.size());
        end else begin
            n_checks++;
            if (obs_eidx[0] != PRE_LEN + 48 + ERR_LAT) begin
                n_fail++; $display("FAIL bad_err_time: got cycle %0d want %0d", obs_eidx[0], PRE_LEN + 48 + ERR_LAT);
            end
        end
        n_checks++;
        if (lock_cnt != PRE_LEN + 48 + ERR_LAT - LOCK_AT) begin
            n_fail++; $display("FAIL bad_hunt: locked for %0d cycles want %0d", lock_cnt, PRE_LEN + 48 + ERR_LAT - LOCK_AT);
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL bad_valid: got %0d valids want 0", obs_q.size()); end
        n_checks++;
        if ({col_out, row_out} !== {4'd7, 4'd5}) begin
            n_fail++; $display("FAIL bad_hold: got col=%0d row=%0d want col=7 row=5", col_out, row_out);
        end
        add_frame(7, 3, 5, 1'b0, lf);
        play();
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {4'd7, 4'd5}) begin
            n_fail++; $display("FAIL bad_recover: got %0d valids want one 7/5", obs_q.size());
        end
    endtask

    task automatic test_overflow();
        int lf0;
        int lf1;
        add_frame(15, 1, 15, 1'b0, lf0);
        add_frame(16, 1, 5, 1'b0, lf1);
        play();
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL ovf_count: got %0d valids want 1", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== {4'd15, 4'd15}) begin
                n_fail++; $display("FAIL ovf_max: got col=%0d row=%0d want col=15 row=15", obs_q[0][7:4], obs_q[0][3:0]);
            end
            n_checks++;
            if (obs_vidx[0] != lf0 + LAT) begin
                n_fail++; $display("FAIL ovf_latency: got cycle %0d want %0d", obs_vidx[0], lf0 + LAT);
            end
        end
        n_checks++;
        if (obs_eidx.size() != 1) begin
            n_fail++; $display("FAIL ovf_err_count: got %0d want 1", obs_eidx.size());
        end else begin
            n_checks++;
            if (obs_eidx[0] != FRAME + PRE_LEN + 16 * 16 + ERR_LAT) begin
                n_fail++; $display("FAIL ovf_err_time: got cycle %0d want %0d", obs_eidx[0], FRAME + PRE_LEN + 256 + ERR_LAT);
            end
        end
    endtask

    task automatic test_isolated_shorts();
        for (int i = 0; i < 5; i++) begin
            add_level(1'b0, $urandom_range(4, 20));
            add_level(1'b1, $urandom_range(1, 2));
        end
        // A 4-toggle burst after a long low run must not add to the earlier shorts.
        add_level(1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            add_level(1'b1, 1);
            add_level(1'b0, 1);
        end
        add_level(1'b0, 200);
        play();
        n_checks++;
        if (lock_cnt != 0) begin n_fail++; $display("FAIL shorts_locked: got %0d locked cycles want 0", lock_cnt); end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL shorts_valid: got %0d want 0", obs_q.size()); end
        n_checks++;
        if (obs_eidx.size() != 0) begin n_fail++; $display("FAIL shorts_err: got %0d want 0", obs_eidx.size()); end
    endtask

    task automatic test_third_group();
        int cl[$];
        int rl[$];
        int lf;
        cl = '{8, 8, 8};
        rl = '{8, 8};
        add_frame_q(cl, 2, rl, 30, lf);
        play();
        n_checks++;
        if (obs_eidx.size() != 1) begin n_fail++; $display("FAIL third_err: got %0d want 1", obs_eidx.size()); end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL third_valid: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back_random();
        int lf;
        int c;
        int r;
        int p;
        for (int f = 0; f < 5; f++) begin
            c = $urandom_range(1, 15);
            r = $urandom_range(1, 15);
            p = $urandom_range(1, 5);
            add_frame(c, p, r, 1'b1, lf);
            exp_q.push_back({4'(c), 4'(r)});
            exp_idx_q.push_back(lf + LAT);
        end
        play();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d valids want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_value[%0d]: got col=%0d row=%0d want col=%0d row=%0d",
                                   i, obs_q[i][7:4], obs_q[i][3:0], exp_q[i][7:4], exp_q[i][3:0]);
            end
            n_checks++;
            if (obs_vidx[i] != exp_idx_q[i]) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got cycle %0d want %0d", i, obs_vidx[i], exp_idx_q[i]);
            end
        end
        n_checks++;
        if (obs_eidx.size() != 0) begin n_fail++; $display("FAIL rand_err: got %0d errs want 0", obs_eidx.size()); end
        exp_q.delete();
        exp_idx_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_min_frame();
        test_reset_mid_frame();
        test_bad_pulse();
        test_overflow();
        test_isolated_shorts();
        test_third_group();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
